striping_nlane: RTL and testbench
=================================

STRIPING_NLANE -- requirements
Module: striping_nlane

Interface
REQ-001 Parameter DATA_W, default 32: width of each input word and each lane.
REQ-002 Parameter LANES, default 4: output lane count; legal range 2..8.
REQ-003 Parameter ADVANCE_ON_IDLE, default 1: 1 = lane pointer advances every cycle; 0 = pointer advances only on an accepted word.
REQ-004 clk_2f  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 data_in  input  DATA_W  input word.
REQ-007 valid_in  input  1  data_in is valid this cycle.
REQ-008 align_in  input  1  force this cycle's slot to lane 0.
REQ-009 lanes_out  output  LANES*DATA_W  registered lane data; lane i occupies bits [i*DATA_W +: DATA_W].
REQ-010 valid_out  output  LANES  per-lane registered valid.
REQ-011 sel_out  output  max(1,$clog2(LANES))  current lane pointer, registered.
REQ-012 round_done  output  1  one-cycle pulse when a valid word lands in lane LANES-1.

Function
REQ-013 Each cycle, the slot lane is 0 if align_in=1; otherwise it is sel_out.
REQ-014 valid_in=1: slot lane data <= data_in and slot lane valid <= 1, visible on the next edge (latency 1 cycle).
REQ-015 valid_in=0: slot lane data <= 0 and slot lane valid <= 0.
REQ-016 Lanes other than the slot lane hold their data and valid unchanged.
REQ-017 Next pointer is slot+1, or 0 when slot=LANES-1 (wrap).
REQ-018 The next pointer is taken every cycle if ADVANCE_ON_IDLE=1; if ADVANCE_ON_IDLE=0 it is taken only when valid_in=1 or align_in=1, else the pointer holds.
REQ-019 If align_in=1 with valid_in=1, the word goes to lane 0 and the pointer becomes 1, discarding any partial round.
REQ-020 round_done is registered: it asserts for exactly one cycle after a valid write to lane LANES-1, including a write caused by wrap.
REQ-021 No backpressure: every valid_in=1 word is accepted; no word is ever dropped or duplicated.

Reset
REQ-022 While reset=1 at a clock edge, and regardless of align_in/valid_in: sel_out=0, all lanes_out=0, valid_out=0, round_done=0.
REQ-023 Reset asserted mid-round discards the partial round; the first word after reset release goes to lane 0.
REQ-024 Reset has priority over align_in and valid_in.

Configuration
REQ-025 Macro STRIPING_NLANE_PARITY_EN, when defined, adds output lane_par [LANES-1:0], which carries the registered even parity (XOR reduction) of each lane's data.
REQ-026 lane_par updates in the same cycle as its lane and resets to 0; a zeroed lane gives parity 0.
REQ-027 With the macro undefined, the lane_par port and its logic are absent; all other behaviour is identical.

Structure
REQ-028 Shared package striping_pkg holds the LANES legal-range constants and the pointer-width function.
REQ-029 One sub-module, striping_lane_reg (data+valid+optional parity register with load/clear), is instantiated LANES times via generate.
REQ-030 The pointer/align logic lives in the top level; there are no latches and no combinational outputs.

Verification (LANES=4, DATA_W=32 unless stated)
REQ-031 Reset, then continuous valid words A0..A7 -> lanes 0,1,2,3,0,1,2,3 in order, each with its lane valid=1; round_done pulses after A3 and after A7.
REQ-032 ADVANCE_ON_IDLE=1, pattern valid,idle,valid with 0x11,-,0x33 -> lane0=0x11; lane1 cleared with valid 0; lane2=0x33; sel_out=3.
REQ-033 ADVANCE_ON_IDLE=0, same pattern -> lane0=0x11, lane1=0x33, sel_out=2.
REQ-034 Words 0xA,0xB, then align_in=1 with 0xC -> lane0=0xC, sel_out=1, and no round_done pulse.
REQ-035 Reset asserted on a cycle with sel_out=2 and valid_in=1 -> all outputs 0 next cycle; the following word goes to lane 0.
REQ-036 Macro defined, word 0x00000007 -> lane_par[slot]=1; word 0x00000003 -> 0; LANES=2 and LANES=8 builds pass REQ-031.

Source files
------------

// File: rtl/striping_pkg.sv
// rtl/striping_pkg.sv - legal lane-count range and lane-pointer width helper for striping_nlane
package striping_pkg;

    localparam int LANES_MIN = 2;
    localparam int LANES_MAX = 8;

    function automatic int ptr_w(input int lanes);
        return (lanes > 2) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/striping_lane_reg.sv
// rtl/striping_lane_reg.sv - one output lane: data, valid and optional parity (STRIPING_NLANE_PARITY_EN)
module striping_lane_reg #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid
`ifdef STRIPING_NLANE_PARITY_EN
    ,
    output logic              o_par
`endif
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (i_clear) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

`ifdef STRIPING_NLANE_PARITY_EN
    // Parity is registered alongside the data so both change on the same edge.
    logic r_par;

    always_ff @(posedge i_clk) begin
        if (i_reset || (i_clear && !i_load)) begin
            r_par <= 1'b0;
        end else if (i_load) begin
            r_par <= ^i_data;
        end
    end

    assign o_par = r_par;
`endif

endmodule

// File: rtl/striping_nlane.sv
// rtl/striping_nlane.sv - stripes a word stream across LANES registered lanes; STRIPING_NLANE_PARITY_EN adds lane_par
module striping_nlane
    import striping_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int LANES           = 4,
    parameter int ADVANCE_ON_IDLE = 1
) (
    input  logic                       clk_2f,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       valid_in,
    input  logic                       align_in,
    output logic [LANES*DATA_W-1:0]    lanes_out,
    output logic [LANES-1:0]           valid_out,
    output logic [ptr_w(LANES)-1:0]    sel_out,
    output logic                       round_done
`ifdef STRIPING_NLANE_PARITY_EN
    ,
    output logic [LANES-1:0]           lane_par
`endif
);

    localparam int               SEL_W = ptr_w(LANES);
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(LANES - 1);

    if (LANES < LANES_MIN || LANES > LANES_MAX) begin : g_bad_lanes
        $error("striping_nlane: LANES out of range");
    end

    logic [SEL_W-1:0] r_sel;
    logic             r_round_done;
    logic [SEL_W-1:0] w_slot;
    logic [SEL_W-1:0] w_next;
    logic             w_adv;

    // Align forces lane 0, so the partial round is abandoned and the next word lands in lane 1.
    assign w_slot = align_in ? '0 : r_sel;
    assign w_next = (w_slot == LAST) ? '0 : w_slot + 1'b1;
    assign w_adv  = (ADVANCE_ON_IDLE != 0) || valid_in || align_in;

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            r_sel        <= '0;
            r_round_done <= 1'b0;
        end else begin
            if (w_adv) begin
                r_sel <= w_next;
            end
            r_round_done <= valid_in && (w_slot == LAST);
        end
    end

    assign sel_out    = r_sel;
    assign round_done = r_round_done;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic w_hit;
        assign w_hit = (w_slot == SEL_W'(i));

        striping_lane_reg #(
            .DATA_W (DATA_W)
        ) u_lane (
            .i_clk   (clk_2f),
            .i_reset (reset),
            .i_load  (w_hit && valid_in),
            .i_clear (w_hit && !valid_in),
            .i_data  (data_in),
            .o_data  (lanes_out[i*DATA_W +: DATA_W]),
            .o_valid (valid_out[i])
`ifdef STRIPING_NLANE_PARITY_EN
            ,
            .o_par   (lane_par[i])
`endif
        );
    end

endmodule

// File: tb/tb_striping_nlane.sv
// tb/tb_striping_nlane.sv - scoreboard bench for striping_nlane (LANES 4/2/8, both ADVANCE_ON_IDLE settings)
module tb_striping_nlane;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic        align_in = 1'b0;
    logic [31:0] data_in = '0;

    logic [127:0] lo0, lo1;
    logic [63:0]  lo2;
    logic [255:0] lo3;
    logic [3:0]   vo0, vo1;
    logic [1:0]   vo2;
    logic [7:0]   vo3;
    logic [1:0]   so0, so1;
    logic         so2;
    logic [2:0]   so3;
    logic         rd0, rd1, rd2, rd3;
`ifdef STRIPING_NLANE_PARITY_EN
    logic [3:0]   po0, po1;
    logic [1:0]   po2;
    logic [7:0]   po3;
`endif

    striping_nlane #(.DATA_W(32), .LANES(4), .ADVANCE_ON_IDLE(1)) dut0 (
        .clk_2f(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in), .align_in(align_in),
        .lanes_out(lo0), .valid_out(vo0), .sel_out(so0), .round_done(rd0)
`ifdef STRIPING_NLANE_PARITY_EN
        , .lane_par(po0)
`endif
    );
    striping_nlane #(.DATA_W(32), .LANES(4), .ADVANCE_ON_IDLE(0)) dut1 (
        .clk_2f(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in), .align_in(align_in),
        .lanes_out(lo1), .valid_out(vo1), .sel_out(so1), .round_done(rd1)
`ifdef STRIPING_NLANE_PARITY_EN
        , .lane_par(po1)
`endif
    );
    striping_nlane #(.DATA_W(32), .LANES(2), .ADVANCE_ON_IDLE(1)) dut2 (
        .clk_2f(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in), .align_in(align_in),
        .lanes_out(lo2), .valid_out(vo2), .sel_out(so2), .round_done(rd2)
`ifdef STRIPING_NLANE_PARITY_EN
        , .lane_par(po2)
`endif
    );
    striping_nlane #(.DATA_W(32), .LANES(8), .ADVANCE_ON_IDLE(1)) dut3 (
        .clk_2f(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in), .align_in(align_in),
        .lanes_out(lo3), .valid_out(vo3), .sel_out(so3), .round_done(rd3)
`ifdef STRIPING_NLANE_PARITY_EN
        , .lane_par(po3)
`endif
    );

    typedef struct packed {
        logic [7:0][31:0] data;
        logic [7:0]       valid;
        logic [7:0]       par;
        logic [2:0]       sel;
        logic             rd;
    } exp_t;

    exp_t sb[$];
    exp_t e, g;
    int   vectors = 0;
    int   errors  = 0;

    int          n_lanes [4] = '{4, 4, 2, 8};
    int          adv     [4] = '{1, 0, 1, 1};
    logic [31:0] m_data  [4][8];
    logic        m_valid [4][8];
    int          m_sel   [4];
    logic        m_rd    [4];

    function automatic exp_t got(input int k);
        exp_t r;
        r = '0;
        case (k)
            0: begin r.data = 256'(lo0); r.valid = 8'(vo0); r.sel = 3'(so0); r.rd = rd0; end
            1: begin r.data = 256'(lo1); r.valid = 8'(vo1); r.sel = 3'(so1); r.rd = rd1; end
            2: begin r.data = 256'(lo2); r.valid = 8'(vo2); r.sel = 3'(so2); r.rd = rd2; end
            default: begin r.data = lo3; r.valid = vo3; r.sel = so3; r.rd = rd3; end
        endcase
`ifdef STRIPING_NLANE_PARITY_EN
        case (k)
            0: r.par = 8'(po0);
            1: r.par = 8'(po1);
            2: r.par = 8'(po2);
            default: r.par = po3;
        endcase
`endif
        return r;
    endfunction

    // Drives one cycle, advances the reference model for every instance and queues its expectation.
    task automatic apply(input logic rst, input logic v, input logic a, input logic [31:0] d);
        exp_t x;
        int   slot;
        reset = rst; valid_in = v; align_in = a; data_in = d;
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                for (int l = 0; l < 8; l++) begin
                    m_data[k][l] = '0; m_valid[k][l] = 1'b0;
                end
                m_sel[k] = 0; m_rd[k] = 1'b0;
            end else begin
                slot = a ? 0 : m_sel[k];
                m_data[k][slot]  = v ? d : 32'h0;
                m_valid[k][slot] = v;
                m_rd[k] = v && (slot == n_lanes[k] - 1);
                if (adv[k] != 0 || v || a)
                    m_sel[k] = (slot == n_lanes[k] - 1) ? 0 : slot + 1;
            end
            x = '0;
            for (int l = 0; l < 8; l++) begin
                x.data[l]  = m_data[k][l];
                x.valid[l] = m_valid[k][l];
`ifdef STRIPING_NLANE_PARITY_EN
                x.par[l]   = ^m_data[k][l];
`endif
            end
            x.sel = 3'(m_sel[k]);
            x.rd  = m_rd[k];
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            apply(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
            for (int k = 0; k < 4; k++) begin
                e = sb.pop_front(); g = got(k); vectors++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL reset_sb inst%0d: got sel=%0d rd=%0b valid=%h data=%h, want sel=%0d rd=%0b valid=%h data=%h",
                             k, g.sel, g.rd, g.valid, g.data, e.sel, e.rd, e.valid, e.data);
                end
            end
        end
        vectors++;
        if (lo0 !== '0 || vo0 !== '0 || so0 !== '0 || rd0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_zero: got lanes=%h valid=%b sel=%0d rd=%b, want all 0", lo0, vo0, so0, rd0);
        end
    endtask

    task automatic test_rounds();
        apply(1'b1, 1'b0, 1'b0, '0);
        void'(sb.pop_front()); void'(sb.pop_front()); void'(sb.pop_front()); void'(sb.pop_front());
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 1'b1, 1'b0, 32'hA000_0000 + 32'(i));
            for (int k = 0; k < 4; k++) begin
                e = sb.pop_front(); g = got(k); vectors++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL rounds_sb inst%0d A%0d: got sel=%0d rd=%0b valid=%h data=%h, want sel=%0d rd=%0b valid=%h data=%h",
                             k, i, g.sel, g.rd, g.valid, g.data, e.sel, e.rd, e.valid, e.data);
                end
            end
            vectors++;
            if (lo0[(i%4)*32 +: 32] !== 32'hA000_0000 + 32'(i) || vo0[i%4] !== 1'b1) begin
                errors++;
                $display("FAIL rounds_lane A%0d: got lane%0d=%h valid=%b, want %h valid=1",
                         i, i % 4, lo0[(i%4)*32 +: 32], vo0[i%4], 32'hA000_0000 + 32'(i));
            end
            vectors++;
            if (rd0 !== (i % 4 == 3) || rd2 !== (i % 2 == 1) || rd3 !== (i == 7)) begin
                errors++;
                $display("FAIL rounds_done A%0d: got rd4=%b rd2=%b rd8=%b, want %b %b %b",
                         i, rd0, rd2, rd3, (i % 4 == 3), (i % 2 == 1), (i == 7));
            end
        end
    endtask

    task automatic test_idle_pattern();
        logic [31:0] dv [3] = '{32'h11, 32'h0, 32'h33};
        logic        vv [3] = '{1'b1, 1'b0, 1'b1};
        apply(1'b1, 1'b0, 1'b0, '0);
        void'(sb.pop_front()); void'(sb.pop_front()); void'(sb.pop_front()); void'(sb.pop_front());
        for (int c = 0; c < 3; c++) begin
            apply(1'b0, vv[c], 1'b0, dv[c]);
            for (int k = 0; k < 4; k++) begin
                e = sb.pop_front(); g = got(k); vectors++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL idle_sb inst%0d cyc%0d: got sel=%0d rd=%0b valid=%h data=%h, want sel=%0d rd=%0b valid=%h data=%h",
                             k, c, g.sel, g.rd, g.valid, g.data, e.sel, e.rd, e.valid, e.data);
                end
            end
        end
        vectors++;
        if (lo0[95:0] !== {32'h33, 32'h0, 32'h11} || vo0[2:0] !== 3'b101 || so0 !== 2'd3) begin
            errors++;
            $display("FAIL idle_adv1: got lanes=%h valid=%b sel=%0d, want 000000330000000000000011 101 3", lo0[95:0], vo0[2:0], so0);
        end
        vectors++;
        if (lo1[63:0] !== {32'h33, 32'h11} || vo1[1:0] !== 2'b11 || so1 !== 2'd2) begin
            errors++;
            $display("FAIL idle_adv0: got lanes=%h valid=%b sel=%0d, want 0000003300000011 11 2", lo1[63:0], vo1[1:0], so1);
        end
    endtask

    task automatic test_align();
        logic [31:0] dv [3] = '{32'hA, 32'hB, 32'hC};
        logic        av [3] = '{1'b0, 1'b0, 1'b1};
        apply(1'b1, 1'b0, 1'b0, '0);
        void'(sb.pop_front()); void'(sb.pop_front()); void'(sb.pop_front()); void'(sb.pop_front());
        for (int c = 0; c < 3; c++) begin
            apply(1'b0, 1'b1, av[c], dv[c]);
            for (int k = 0; k < 4; k++) begin
                e = sb.pop_front(); g = got(k); vectors++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL align_sb inst%0d cyc%0d: got sel=%0d rd=%0b valid=%h data=%h, want sel=%0d rd=%0b valid=%h data=%h",
                             k, c, g.sel, g.rd, g.valid, g.data, e.sel, e.rd, e.valid, e.data);
                end
            end
        end
        vectors++;
        if (lo0[31:0] !== 32'hC || so0 !== 2'd1 || rd0 !== 1'b0) begin
            errors++;
            $display("FAIL align_lane0: got lane0=%h sel=%0d rd=%b, want c 1 0", lo0[31:0], so0, rd0);
        end
    endtask

    task automatic test_reset_mid();
        logic        rv [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] dv [4] = '{32'h1, 32'h2, 32'h3, 32'h4};
        apply(1'b1, 1'b0, 1'b0, '0);
        void'(sb.pop_front()); void'(sb.pop_front()); void'(sb.pop_front()); void'(sb.pop_front());
        for (int c = 0; c < 4; c++) begin
            apply(rv[c], 1'b1, 1'b0, dv[c]);
            for (int k = 0; k < 4; k++) begin
                e = sb.pop_front(); g = got(k); vectors++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL rstmid_sb inst%0d cyc%0d: got sel=%0d rd=%0b valid=%h data=%h, want sel=%0d rd=%0b valid=%h data=%h",
                             k, c, g.sel, g.rd, g.valid, g.data, e.sel, e.rd, e.valid, e.data);
                end
            end
            if (c == 2) begin
                vectors++;
                if (lo0 !== '0 || vo0 !== '0 || so0 !== '0 || rd0 !== 1'b0) begin
                    errors++;
                    $display("FAIL rstmid_zero: got lanes=%h valid=%b sel=%0d rd=%b, want all 0", lo0, vo0, so0, rd0);
                end
            end
        end
        vectors++;
        if (lo0[31:0] !== 32'h4 || vo0 !== 4'b0001 || so0 !== 2'd1) begin
            errors++;
            $display("FAIL rstmid_first: got lane0=%h valid=%b sel=%0d, want 4 0001 1", lo0[31:0], vo0, so0);
        end
    endtask

    task automatic test_parity();
        logic [31:0] dv [3] = '{32'h7, 32'h3, 32'h0};
        logic        vv [3] = '{1'b1, 1'b1, 1'b0};
        apply(1'b1, 1'b0, 1'b0, '0);
        void'(sb.pop_front()); void'(sb.pop_front()); void'(sb.pop_front()); void'(sb.pop_front());
        for (int c = 0; c < 3; c++) begin
            apply(1'b0, vv[c], 1'b0, dv[c]);
            for (int k = 0; k < 4; k++) begin
                e = sb.pop_front(); g = got(k); vectors++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL parity_sb inst%0d cyc%0d: got par=%h valid=%h data=%h, want par=%h valid=%h data=%h",
                             k, c, g.par, g.valid, g.data, e.par, e.valid, e.data);
                end
            end
        end
`ifdef STRIPING_NLANE_PARITY_EN
        vectors++;
        if (po0[2:0] !== 3'b001) begin
            errors++;
            $display("FAIL parity_bits: got lane_par[2:0]=%b, want 001", po0[2:0]);
        end
`endif
    endtask

    task automatic test_random();
        logic r, v, a;
        for (int c = 0; c < 300; c++) begin
            r = ($urandom_range(0, 31) == 0);
            v = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 7) == 0);
            apply(r, v, a, $urandom);
            for (int k = 0; k < 4; k++) begin
                e = sb.pop_front(); g = got(k); vectors++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL random_sb inst%0d cyc%0d: got sel=%0d rd=%0b valid=%h par=%h, want sel=%0d rd=%0b valid=%h par=%h",
                             k, c, g.sel, g.rd, g.valid, g.par, e.sel, e.rd, e.valid, e.par);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rounds();
        test_idle_pattern();
        test_align();
        test_reset_mid();
        test_parity();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
